// File: rtl/bounce_pkg.sv
// -----------------------------------------------------------------------------
// bounce_pkg
// Shared definitions for the bounce-waveform stimulus blocks:
//   LFSR_MASK      - Galois feedback mask for x^16+x^14+x^13+x^11+1
//   state_e        - bounce_generator FSM encoding (IDLE=0, BOUNCE=1, SETTLE=2)
//   worst_case_len - longest edge-to-settled sequence for a given configuration
// -----------------------------------------------------------------------------
package bounce_pkg;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Every pair contributes two segments of at most 2^gap_w cycles each.
  function automatic int worst_case_len(input int bounce_w, input int gap_w,
                                        input int settle_cycles);
    return 2 * ((1 << bounce_w) - 1) * (1 << gap_w) + settle_cycles;
  endfunction

endpackage

// File: rtl/bounce_generator_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// 16-bit Galois LFSR, right-shifting, feedback mask LFSR_MASK.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high; loads seed (zero seed becomes 16'h0001)
//   en    - advance one step per cycle when high, hold when low
//   seed  - reset value
//   q     - current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_nz;
  logic [15:0] q_q;

  // An all-zero state would lock the register up forever.
  assign seed_nz = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= seed_nz;
    end else if (en) begin
      q_q <= q_q[0] ? ((q_q >> 1) ^ LFSR_MASK) : (q_q >> 1);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bounce_generator.sv
// -----------------------------------------------------------------------------
// bounce_generator
// Turns a clean synchronous level into a contact-bounce waveform: an initial
// edge, an even number of pseudo-random glitch toggles, then a settle period.
// Ports:
//   clk       - clock, rising edge
//   reset     - synchronous active-high reset
//   enable    - 1 = bounce mode, 0 = bypass (noisy_out follows clean_in, 1 cycle)
//   clean_in  - desired level
//   noisy_out - registered bounce waveform
//   busy      - high while in BOUNCE or SETTLE
//   settled   - one-cycle pulse when a sequence completes
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | noisy_out holds target; launches a sequence on clean_in!=target
// BOUNCE | counting segment lengths, toggling noisy_out at each segment end
// SETTLE | holding target for SETTLE_CYCLES, then pulse settled
// -----------------------------------------------------------------------------
module bounce_generator
  import bounce_pkg::*;
#(
  parameter logic [15:0] SEED          = 16'hACE1,
  parameter int          BOUNCE_W      = 3,
  parameter int          GAP_W         = 6,
  parameter int          SETTLE_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clean_in,
  output logic noisy_out,
  output logic busy,
  output logic settled
);

  localparam int TOG_W = BOUNCE_W + 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

  state_e              state_q;
  logic                noisy_q;
  logic                target_q;
  logic                settled_q;
  logic [TOG_W-1:0]    toggles_q;
  logic [GAP_W-1:0]    seg_q;
  logic [SET_W-1:0]    settle_q;

  logic [15:0]         lfsr_q;
  logic [BOUNCE_W-1:0] pairs;
  logic [GAP_W-1:0]    gap;
  logic                unused_lfsr;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (enable),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign pairs       = lfsr_q[BOUNCE_W-1:0];
  assign gap         = lfsr_q[BOUNCE_W+GAP_W-1:BOUNCE_W];
  assign unused_lfsr = ^lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      noisy_q   <= 1'b0;
      target_q  <= 1'b0;
      settled_q <= 1'b0;
      toggles_q <= '0;
      seg_q     <= '0;
      settle_q  <= '0;
    end else if (!enable) begin
      // Bypass also aborts any sequence in flight, without a settled pulse.
      state_q   <= IDLE;
      target_q  <= clean_in;
      noisy_q   <= clean_in;
      settled_q <= 1'b0;
    end else begin
      settled_q <= 1'b0;
      case (state_q)
        IDLE: begin
          noisy_q <= target_q;
          if (clean_in != target_q) begin
            target_q <= clean_in;
            noisy_q  <= clean_in;
            if (pairs == '0) begin
              state_q  <= SETTLE;
              settle_q <= SETTLE_LOAD;
            end else begin
              toggles_q <= {pairs, 1'b0};
              seg_q     <= gap;
              state_q   <= BOUNCE;
            end
          end
        end
        BOUNCE: begin
          if (seg_q != '0) begin
            seg_q <= seg_q - GAP_W'(1);
          end else begin
            noisy_q   <= ~noisy_q;
            toggles_q <= toggles_q - TOG_W'(1);
            // Even toggle count: the last toggle lands back on target.
            if (toggles_q == TOG_W'(1)) begin
              state_q  <= SETTLE;
              settle_q <= SETTLE_LOAD;
            end else begin
              seg_q <= gap;
            end
          end
        end
        SETTLE: begin
          noisy_q <= target_q;
          if (settle_q == '0) begin
            settled_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            settle_q <= settle_q - SET_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          noisy_q <= target_q;
        end
      endcase
    end
  end

  assign noisy_out = noisy_q;
  assign settled   = settled_q;
  assign busy      = (state_q == BOUNCE) || (state_q == SETTLE);

endmodule

// File: tb/tb_bounce_generator.sv
// -----------------------------------------------------------------------------
// tb_bounce_generator
// Self-checking bench for bounce_generator. Expected per-cycle outputs are
// built from an independent LFSR model and pushed to a scoreboard when an edge
// is driven; they are popped and compared one cycle at a time. A behavioural
// debouncer closes the loop for the random-edge test.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bounce_generator;
  import bounce_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int BW = 3;
  localparam int GW = 6;
  localparam int SC = 32;
  localparam int WORST = worst_case_len(BW, GW, SC);
  localparam int DEB_TIMER = (1 << GW) + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic clean_in = 1'b0;
  logic noisy_out, busy, settled;

  bounce_generator #(
    .SEED(SEED), .BOUNCE_W(BW), .GAP_W(GW), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clean_in(clean_in),
    .noisy_out(noisy_out), .busy(busy), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic noisy;
    logic busy;
    logic settled;
  } exp_t;

  exp_t exp_q[$];
  logic lvl_q[$];
  int   toggle_edges[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Independent LFSR model: x^16+x^14+x^13+x^11+1, Galois, right shift.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] model_step(input logic [15:0] v);
    logic fb;
    fb = v[0];
    v = {1'b0, v[15:1]};
    if (fb) v = v ^ 16'hB400;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else if (enable) m_lfsr <= model_step(m_lfsr);
  end

  // Behavioural debouncer: flips after DEB_TIMER consecutive disagreeing samples.
  logic deb_out;
  int   deb_cnt;
  int   deb_trans;
  always @(posedge clk) begin
    if (reset) begin
      deb_out <= 1'b0; deb_cnt <= 0; deb_trans <= 0;
    end else if (noisy_out == deb_out) begin
      deb_cnt <= 0;
    end else if (deb_cnt == DEB_TIMER - 1) begin
      deb_out <= noisy_out; deb_cnt <= 0; deb_trans <= deb_trans + 1;
    end else begin
      deb_cnt <= deb_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs after edges 1..N of a sequence toward v, where 'start'
  // is the LFSR value seen by the DUT at the edge that samples the change.
  task automatic push_seq(input logic v, input logic [15:0] start);
    logic [15:0] l;
    int li, k, s, t, last, idx;
    logic lvl;
    exp_t e;
    l = start; li = 1;
    k = int'(start[BW-1:0]);
    s = int'(start[BW+GW-1:BW]);
    t = 1;
    toggle_edges.delete();
    for (int i = 0; i < 2 * k; i++) begin
      t = t + s + 1;
      toggle_edges.push_back(t);
      while (li < t) begin l = model_step(l); li++; end
      s = int'(l[BW+GW-1:BW]);
    end
    last = t;
    lvl = v; idx = 0;
    for (int j = 1; j <= last + SC; j++) begin
      if (idx < toggle_edges.size() && toggle_edges[idx] == j) begin
        lvl = ~lvl; idx++;
      end
      e.noisy = lvl;
      e.busy = (j < last + SC);
      e.settled = (j == last + SC);
      exp_q.push_back(e);
    end
  endtask

  // Idle (enable=1, no edge) until the model LFSR pair field is in [lo,hi].
  task automatic wait_pairs(input int lo, input int hi);
    int n;
    n = 0;
    while (!(int'(m_lfsr[BW-1:0]) >= lo && int'(m_lfsr[BW-1:0]) <= hi) && n < 400) begin
      tick(); n++;
    end
    n_vec++;
    if (!(int'(m_lfsr[BW-1:0]) >= lo && int'(m_lfsr[BW-1:0]) <= hi)) begin
      n_err++;
      $display("FAIL wait_pairs: pair field %0d not in [%0d,%0d] within 400 cycles",
               m_lfsr[BW-1:0], lo, hi);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clean_in = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (dut.lfsr_q !== SEED) begin
      n_err++; $display("FAIL reset_lfsr: got %h required %h", dut.lfsr_q, SEED);
    end
    n_vec++;
    if ({noisy_out, busy, settled} !== 3'b000) begin
      n_err++; $display("FAIL reset_outs: n/b/s got %b required 000", {noisy_out, busy, settled});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); n_vec++;
      if ({noisy_out, busy, settled} !== 3'b000) begin
        n_err++; $display("FAIL reset_idle cyc %0d: n/b/s got %b required 000", i, {noisy_out, busy, settled});
      end
    end
  endtask

  task automatic test_bypass();
    logic pat [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e;
    enable = 1'b0;
    tick();
    n_vec++;
    if ({noisy_out, busy, settled} !== 3'b000) begin
      n_err++; $display("FAIL bypass_start: n/b/s got %b required 000", {noisy_out, busy, settled});
    end
    for (int i = 0; i < 4; i++) begin
      clean_in = pat[i];
      e.noisy = pat[i]; e.busy = 1'b0; e.settled = 1'b0;
      exp_q.push_back(e);
      tick();
      e = exp_q.pop_front();
      n_vec++;
      if ({noisy_out, busy, settled} !== e) begin
        n_err++; $display("FAIL bypass step %0d: n/b/s got %b required %b", i, {noisy_out, busy, settled}, e);
      end
    end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_bounce(input logic v);
    exp_t e;
    int j;
    wait_pairs(1, 7);
    clean_in = v;
    push_seq(v, m_lfsr);
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); j++; n_vec++;
      if ({noisy_out, busy, settled} !== e) begin
        n_err++; $display("FAIL bounce_to_%0b edge %0d: n/b/s got %b required %b", v, j, {noisy_out, busy, settled}, e);
      end
    end
  endtask

  task automatic test_no_bounce();
    exp_t e;
    int j;
    wait_pairs(0, 0);
    clean_in = 1'b1;
    push_seq(1'b1, m_lfsr);
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); j++; n_vec++;
      if ({noisy_out, busy, settled} !== e) begin
        n_err++; $display("FAIL no_bounce edge %0d: n/b/s got %b required %b", j, {noisy_out, busy, settled}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int j, flip_at;
    wait_pairs(2, 7);
    clean_in = 1'b1;
    push_seq(1'b1, m_lfsr);
    flip_at = toggle_edges[2];
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); j++; n_vec++;
      if ({noisy_out, busy, settled} !== e) begin
        n_err++; $display("FAIL b2b_rise edge %0d: n/b/s got %b required %b", j, {noisy_out, busy, settled}, e);
      end
      if (j == flip_at) clean_in = 1'b0;
    end
    // Pending mismatch must launch on the very next edge.
    push_seq(1'b0, m_lfsr);
    j = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); tick(); j++; n_vec++;
      if ({noisy_out, busy, settled} !== e) begin
        n_err++; $display("FAIL b2b_fall edge %0d: n/b/s got %b required %b", j, {noisy_out, busy, settled}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_pairs(1, 7);
    clean_in = 1'b1;
    tick();
    n_vec++;
    if ({noisy_out, busy} !== 2'b11) begin
      n_err++; $display("FAIL mid_pre: n/b got %b required 11", {noisy_out, busy});
    end
    reset = 1'b1; clean_in = 1'b0;
    tick();
    n_vec++;
    if ({noisy_out, busy, settled} !== 3'b000) begin
      n_err++; $display("FAIL mid_reset_outs: n/b/s got %b required 000", {noisy_out, busy, settled});
    end
    n_vec++;
    if (dut.state_q !== IDLE) begin
      n_err++; $display("FAIL mid_reset_state: got %0d required %0d", dut.state_q, IDLE);
    end
    n_vec++;
    if (dut.lfsr_q !== SEED) begin
      n_err++; $display("FAIL mid_reset_lfsr: got %h required %h", dut.lfsr_q, SEED);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(); n_vec++;
      if ({noisy_out, busy, settled} !== 3'b000) begin
        n_err++; $display("FAIL mid_after cyc %0d: n/b/s got %b required 000", i, {noisy_out, busy, settled});
      end
    end
  endtask

  task automatic test_closed_loop();
    int base, cnt;
    logic want;
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 15)) tick();
      base = deb_trans;
      clean_in = ~clean_in;
      lvl_q.push_back(clean_in);
      cnt = 0;
      tick();
      while (!settled && cnt < WORST + 5) begin tick(); cnt++; end
      n_vec++;
      if (!settled) begin
        n_err++; $display("FAIL loop %0d settled: got 0 required 1 within %0d cycles", i, WORST + 5);
      end
      repeat (DEB_TIMER + 8) tick();
      want = lvl_q.pop_front();
      n_vec++;
      if (deb_out !== want || noisy_out !== want) begin
        n_err++; $display("FAIL loop %0d level: deb %b noisy %b required %b", i, deb_out, noisy_out, want);
      end
      n_vec++;
      if (deb_trans - base != 1) begin
        n_err++; $display("FAIL loop %0d transitions: got %0d required 1", i, deb_trans - base);
      end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_bounce(1'b1);
    test_bounce(1'b0);
    test_no_bounce();
    test_bounce(1'b0);
    test_back_to_back();
    test_reset_mid();
    test_closed_loop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
Name: bounce_generator

Overview:
- Stimulus-side counterpart to the team's debouncer: converts a clean, synchronous level `clean_in` into a contact-bounce waveform on `noisy_out`.
- Each accepted level change produces:
  - an initial edge,
  - then a pseudo-random, even number of glitch toggles with pseudo-random spacing,
  - then a settle period on the new level.
- Used in hardware-in-loop tests and FPGA demos to exercise the debouncer and edge detector without a physical switch.

Parameters:
- SEED, 16'hACE1, LFSR reset value. A value of 0 is replaced by 16'h0001.
- BOUNCE_W, 3, width of the bounce-pair count. Pairs per edge = 0..2^BOUNCE_W-1.
- GAP_W, 6, width of the segment length. Each segment lasts 1..2^GAP_W cycles.
- SETTLE_CYCLES, 32, cycles held stable after the last toggle before the block returns to IDLE. Must be ≥1.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = bounce mode, 0 = bypass mode
- clean_in  input  1  desired level; synchronous to clk
- noisy_out  output  1  registered bounce waveform
- busy  output  1  high while in BOUNCE or SETTLE
- settled  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (reset=1 at a clk edge), effective next cycle:
  - state=IDLE, noisy_out=0, target=0, busy=0, settled=0.
  - lfsr=SEED, all counters 0.
  - Reset overrides every other input, including mid-BOUNCE/SETTLE.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400).
  - Advances every cycle when enable=1; holds when enable=0.
  - All "lfsr" field reads below use the current (pre-advance) value.
- Bypass (enable=0):
  - State forced to IDLE; target<=clean_in; noisy_out<=clean_in (1-cycle latency).
  - busy=0, settled=0.
  - Deasserting enable mid-sequence aborts the sequence the next cycle, with no settled pulse.
- IDLE (enable=1):
  - noisy_out holds target.
  - If clean_in==target: remain in IDLE.
  - If clean_in!=target: target<=clean_in and noisy_out<=clean_in (initial edge, 1 cycle after clean_in is sampled). Then:
    - pairs k = lfsr[BOUNCE_W-1:0].
    - If k=0: go to SETTLE.
    - Else: toggles_left<=2k, seg_cnt<=lfsr[BOUNCE_W+GAP_W-1:BOUNCE_W], go to BOUNCE.
- BOUNCE:
  - If seg_cnt!=0: seg_cnt decrements.
  - If seg_cnt==0:
    - noisy_out toggles and toggles_left decrements.
    - If toggles_left was 1: go to SETTLE with settle_cnt<=SETTLE_CYCLES-1.
    - Else: seg_cnt reloads from the same LFSR field.
  - Segment length is seg_cnt+1 cycles.
  - Because the toggle count is even, noisy_out==target on exit.
- SETTLE:
  - noisy_out holds target; settle_cnt decrements.
  - At 0: settled=1 for one cycle and state goes to IDLE.
  - The k=0 path also loads settle_cnt<=SETTLE_CYCLES-1.
- clean_in changes during BOUNCE/SETTLE are ignored.
  - IDLE re-samples on its first cycle, so a pending mismatch starts a new sequence the cycle after settled.
  - This makes back-to-back edges deterministic.
- busy:
  - Combinational from the state.
  - Low in IDLE, including the cycle in which the initial edge is launched.
- Worst-case sequence length: 2(2^BOUNCE_W-1)·2^GAP_W + SETTLE_CYCLES cycles.
- Maximum glitch gap is 2^GAP_W cycles. A downstream debouncer timer must exceed this for clean detection.
- Unused FSM encodings recover to IDLE.

Decomposition:
- Shared package (bounce_pkg) holds:
  - the LFSR mask constant 16'hB400,
  - the state localparams IDLE=0, BOUNCE=1, SETTLE=2,
  - a helper function for the worst-case length.
- One sub-module: lfsr16.
  - Ports: clk, reset, en, seed, q.
  - Galois step; zero seed maps to 1.
  - Reused by future stimulus blocks.
- The FSM and counters stay in bounce_generator.

Test Plan:
- Reset held 3 cycles, then released with enable=1, clean_in=0:
  - noisy_out=0, busy=0, settled=0 throughout.
  - Internal lfsr equals 16'hACE1 on the first post-reset cycle.
- enable=0, clean_in pattern 0,1,1,0 on consecutive cycles:
  - noisy_out = 0,0,1,1,0 (1-cycle delay).
  - busy and settled stay 0.
- enable=1, clean_in 0→1, checked against a bench LFSR model:
  - noisy_out rises 1 cycle later.
  - Exactly 2k further toggles with gaps matching model values (k from lfsr[2:0]).
  - Final level 1; settled pulses exactly 32 cycles after the last toggle.
- Seed chosen so lfsr[2:0]=0 at the edge:
  - single clean edge, no toggles.
  - settled pulses 32 cycles later.
- clean_in 0→1, then back to 0 at the 3rd toggle:
  - sequence completes at level 1 with a settled pulse.
  - Next cycle the block starts a new sequence toward 0.
- reset pulsed mid-BOUNCE while noisy_out=1:
  - next cycle noisy_out=0, busy=0, state IDLE, lfsr=SEED, with no settled pulse.
- Closed loop with the debouncer (timer = 2^GAP_W+4 cycles), 100 random clean_in edges spaced beyond the worst-case length:
  - debouncer output shows exactly one transition per clean_in edge.
  - debouncer final level equals clean_in.
